// File: rtl/cla_nibble_seq_if.sv
// Host-side request/result bundle for cla_nibble_seq; the optional sub bit
// exists only when CLA_NIBBLE_SEQ_SUB_EN is defined.
interface cla_nibble_seq_if;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
`ifdef CLA_NIBBLE_SEQ_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    modport master (
        output start, op_a, op_b, cin,
`ifdef CLA_NIBBLE_SEQ_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, op_a, op_b, cin,
`ifdef CLA_NIBBLE_SEQ_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/cla_nibble_seq.sv
// 16-bit add sequenced through an external registered 4-bit CLA stage, LSB nibble first (CLA_NIBBLE_SEQ_SUB_EN adds subtract).
// Latency: done pulses 12 cycles after the start-accept edge, 3 cycles per nibble.
// Backpressure: none; start is only sampled in IDLE, so requests while busy are dropped.
module cla_nibble_seq (
    input  logic            clk,
    input  logic            rst,
    cla_nibble_seq_if.slave host,
    output logic [3:0]      add_a,
    output logic [3:0]      add_b,
    output logic            add_cin,
    input  logic [3:0]      add_s,
    input  logic            add_cout
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT2, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        step;
    logic [1:0]  k;
    logic [11:0] a_sh;
    logic [11:0] b_sh;
    logic [15:0] sum_r;
    logic        cout_r;
    logic [15:0] b_in;
    logic        c_in;

    // Subtract is a + ~b + 1; the inversion is applied once at accept time.
`ifdef CLA_NIBBLE_SEQ_SUB_EN
    assign b_in = host.sub ? ~host.op_b : host.op_b;
    assign c_in = host.cin | host.sub;
`else
    assign b_in = host.op_b;
    assign c_in = host.cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        host.busy = 1'b0;
        host.done = 1'b0;
        case (state)
            IDLE: begin
                if (host.start) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                host.busy = 1'b1;
                state_nxt = WAIT1;
            end
            WAIT1: begin
                host.busy = 1'b1;
                state_nxt = WAIT2;
            end
            WAIT2: begin
                host.busy = 1'b1;
                step      = 1'b1;
                state_nxt = (k == 2'd3) ? DONE : ISSUE;
            end
            DONE: begin
                host.done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Upper operand nibbles shift down so the next nibble is always at [3:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            k       <= 2'd0;
            a_sh    <= 12'd0;
            b_sh    <= 12'd0;
            sum_r   <= 16'd0;
            cout_r  <= 1'b0;
            add_a   <= 4'd0;
            add_b   <= 4'd0;
            add_cin <= 1'b0;
        end else if (accept) begin
            k       <= 2'd0;
            a_sh    <= host.op_a[15:4];
            b_sh    <= b_in[15:4];
            sum_r   <= 16'd0;
            add_a   <= host.op_a[3:0];
            add_b   <= b_in[3:0];
            add_cin <= c_in;
        end else if (step) begin
            sum_r[{k, 2'b00} +: 4] <= add_s;
            if (k == 2'd3) begin
                cout_r <= add_cout;
            end else begin
                k       <= k + 2'd1;
                add_a   <= a_sh[3:0];
                add_b   <= b_sh[3:0];
                add_cin <= add_cout;
                a_sh    <= a_sh >> 4;
                b_sh    <= b_sh >> 4;
            end
        end
    end

    assign host.sum  = sum_r;
    assign host.cout = cout_r;

endmodule

// File: doc/cla_nibble_seq.md
CLA_NIBBLE_SEQ -- requirements
Module: cla_nibble_seq

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL provide ports: clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset; shared with the registered 4-bit CLA stage.
REQ-004 start  input  1  request a 16-bit add; sampled in IDLE only.
REQ-005 op_a  input  16  operand A; latched when start is accepted.
REQ-006 op_b  input  16  operand B; latched when start is accepted.
REQ-007 cin  input  1  carry-in; latched when start is accepted.
REQ-008 add_a / add_b  output  4 each  nibble operands to the CLA stage; registered.
REQ-009 add_cin  output  1  nibble carry-in to the CLA stage; registered.
REQ-010 add_s  input  4  registered sum from the CLA stage.
REQ-011 add_cout  input  1  registered carry from the CLA stage.
REQ-012 busy  output  1  high while a nibble is in flight.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 sum  output  16  assembled result; held until the next accepted start.
REQ-015 cout  output  1  final carry; held like sum.

Function
REQ-016 SHALL compute {cout,sum} = op_a + op_b + cin by driving the CLA stage one nibble at a time, nibble 0 (LSB) first, with all arithmetic modulo 2^16 plus carry.
REQ-017 SHALL treat the CLA stage as a fixed 2-edge pipeline: inputs are captured on edge N, and the result is valid on add_s/add_cout after edge N+1.
REQ-018 SHALL use the FSM states IDLE, ISSUE, WAIT1, WAIT2, DONE.
REQ-019 IDLE -> ISSUE occurs on the edge where start=1; that edge latches op_a, op_b and cin, clears nibble index k to 0, clears sum, and loads add_a=op_a[3:0], add_b=op_b[3:0], add_cin=cin.
REQ-020 ISSUE -> WAIT1 -> WAIT2 are unconditional single cycles; add_a, add_b and add_cin SHALL be held stable through all three.
REQ-021 The WAIT2 exit edge SHALL write add_s into sum[4k+3:4k].
REQ-022 On the WAIT2 exit edge with k<3, the FSM SHALL go to ISSUE with k+1 and load the next nibble, with add_cin = add_cout.
REQ-023 On the WAIT2 exit edge with k=3, the FSM SHALL write cout = add_cout and go to DONE.
REQ-024 Latency: done SHALL be high exactly 12 cycles after the start-accept edge; each nibble takes 3 cycles.
REQ-025 DONE SHALL last one cycle and then return to IDLE; done=1 only in DONE.
REQ-026 busy SHALL be 1 in ISSUE, WAIT1 and WAIT2, and 0 in IDLE and DONE.
REQ-027 start in any state other than IDLE SHALL be ignored, and the latched operands SHALL be unchanged.
REQ-028 start=1 held continuously SHALL start a new operation on the first IDLE cycle after DONE.
REQ-029 Changes on op_a, op_b or cin after the accept edge SHALL have no effect on the result.

Reset
REQ-030 rst=1 on an edge SHALL force state IDLE and k=0, and SHALL clear sum, cout, add_a, add_b, add_cin, busy and done to 0.
REQ-031 rst takes priority over start and over any state transition.
REQ-032 rst mid-operation SHALL abort the operation with no done pulse; the next start SHALL run a full 12-cycle operation.

Configuration
REQ-033 With macro CLA_NIBBLE_SEQ_SUB_EN defined, the block SHALL add input port sub (1 bit), latched with start.
REQ-034 With the macro defined and sub=1, the block SHALL drive add_b = ~op_b nibble and force the nibble-0 carry-in to 1, ignoring cin, giving sum = op_a - op_b and cout = 1 when there is no borrow.
REQ-035 With the macro defined and sub=0, behaviour SHALL be identical to the macro undefined.
REQ-036 Without the macro, the sub port SHALL be absent and the block SHALL be add-only.

Verification
REQ-037 op_a=0x1234, op_b=0x4321, cin=0, start -> done 12 cycles later; sum=0x5555, cout=0; busy high for 12 cycles.
REQ-038 op_a=0xFFFF, op_b=0x0001, cin=0 -> sum=0x0000, cout=1; add_cin=1 observed for nibbles 1-3.
REQ-039 op_a=0xFFFF, op_b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1; operands changed to 0 one cycle after accept do not affect the result.
REQ-040 Start with 0x00FF+0x0001, then pulse start again at cycle 5 with other operands -> second start ignored; sum=0x0100 at done.
REQ-041 Assert rst at cycle 7 of an operation -> no done pulse; all outputs 0 the next cycle; a following 0x0003+0x0004 gives sum=0x0007 after 12 cycles.
REQ-042 With CLA_NIBBLE_SEQ_SUB_EN defined, sub=1, 0x0005-0x0007 -> sum=0xFFFE, cout=0; 0x0007-0x0005 -> sum=0x0002, cout=1.
